// File: rtl/spi_cmd_ctrl.sv
// Command decoder / sequencer behind the SPI byte slave.
// Parses one framed command stream per chip-select assertion and drives the
// control register file, the framebuffer write port and the read-back byte.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for a command byte
// S_REG_ADDR | WRITE_REG: next byte is the register address
// S_REG_DATA | WRITE_REG: next byte is the register data
// S_RD_ADDR  | READ_REG: next byte is the register address to stage on tx
// S_PIX_AH   | PIXEL_BURST: next byte is the high address byte
// S_PIX_AL   | PIXEL_BURST: next byte is the low address byte
// S_PIX_DATA | PIXEL_BURST: every byte is a pixel, address auto-increments
// S_DISCARD  | protocol error seen, swallow bytes until the frame ends
module spi_cmd_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int FB_DEPTH = 19200,
    parameter int NUM_REGS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  cs_n_sync,
    output logic [7:0]            tx_data,
    output logic                  fb_we,
    output logic [ADDR_W-1:0]     fb_addr,
    output logic [7:0]            fb_wdata,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  busy,
    output logic                  err
);

    localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);
    localparam logic [31:0]       FB_DEPTH_W = 32'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] FB_LAST    = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG_ADDR,
        S_REG_DATA,
        S_RD_ADDR,
        S_PIX_AH,
        S_PIX_AL,
        S_PIX_DATA,
        S_DISCARD
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        addr_q;
    logic [7:0]        hi_q;
    logic [7:0]        regs [NUM_REGS];
    logic [15:0]       pix_full;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    logic cmd_bad, reg_wr, reg_bad, rd_hit, rd_bad, pix_load, pix_bad, pix_wr;

    // Start address is compared after truncation to the framebuffer width.
    assign pix_full = {hi_q, rx_data};
    assign pix_addr = pix_full[ADDR_W-1:0];
    assign pix_ok   = {{(32-ADDR_W){1'b0}}, pix_addr} < FB_DEPTH_W;
    assign wr_idx   = addr_q[IDX_W-1:0];
    assign rd_idx   = rx_data[IDX_W-1:0];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_out[8*gi +: 8] = regs[gi];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: a received byte always wins over a frame end in the same cycle.
    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    case (rx_data)
                        8'h00:   state_nxt = S_IDLE;
                        8'h01:   state_nxt = S_REG_ADDR;
                        8'h02:   state_nxt = S_RD_ADDR;
                        8'h03:   state_nxt = S_PIX_AH;
                        default: state_nxt = S_DISCARD;
                    endcase
                end
                S_REG_ADDR: state_nxt = S_REG_DATA;
                S_REG_DATA: state_nxt = S_IDLE;
                S_RD_ADDR:  state_nxt = S_IDLE;
                S_PIX_AH:   state_nxt = S_PIX_AL;
                S_PIX_AL:   state_nxt = pix_ok ? S_PIX_DATA : S_DISCARD;
                S_PIX_DATA: state_nxt = S_PIX_DATA;
                S_DISCARD:  state_nxt = S_DISCARD;
                default:    state_nxt = S_IDLE;
            endcase
        end else if (cs_n_sync) begin
            state_nxt = S_IDLE;
        end
    end

    // Output decode: busy plus the per-byte actions consumed by the datapath.
    always_comb begin
        busy     = (state != S_IDLE);
        cmd_bad  = rx_valid && (state == S_IDLE) && (rx_data > 8'h03);
        reg_wr   = rx_valid && (state == S_REG_DATA) && (addr_q < NUM_REGS_B);
        reg_bad  = rx_valid && (state == S_REG_DATA) && (addr_q >= NUM_REGS_B);
        rd_hit   = rx_valid && (state == S_RD_ADDR) && (rx_data < NUM_REGS_B);
        rd_bad   = rx_valid && (state == S_RD_ADDR) && (rx_data >= NUM_REGS_B);
        pix_load = rx_valid && (state == S_PIX_AL) && pix_ok;
        pix_bad  = rx_valid && (state == S_PIX_AL) && !pix_ok;
        pix_wr   = rx_valid && (state == S_PIX_DATA);
    end

    // Datapath: registered outputs, one clock after the byte that caused them.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data  <= 8'h00;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= 8'h00;
            err      <= 1'b0;
            addr_q   <= 8'h00;
            hi_q     <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            err   <= cmd_bad | reg_bad | rd_bad | pix_bad;
            fb_we <= pix_wr;
            if (pix_wr) fb_wdata <= rx_data;
            // Advance the address the cycle after each write strobe.
            if (fb_we) fb_addr <= (fb_addr == FB_LAST) ? '0 : fb_addr + ADDR_ONE;
            if (pix_load) fb_addr <= pix_addr;
            if (rx_valid && state == S_REG_ADDR) addr_q <= rx_data;
            if (rx_valid && state == S_PIX_AH)   hi_q   <= rx_data;
            if (reg_wr) regs[wr_idx] <= rx_data;
            if (rd_hit) tx_data <= regs[rd_idx];
            if (rd_bad) tx_data <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: a table of single-frame vectors applied in
// order (register/tx expectations are cumulative), followed by hand-written
// sequences for the long pixel burst, byte-with-frame-end and mid-frame reset.
module tb_spi_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cs_n_sync = 1'b1;
    logic [7:0]  tx_data;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic [63:0] reg_out;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    logic        prev_we = 1'b0;
    logic [23:0] wlog[$];

    spi_cmd_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cs_n_sync (cs_n_sync),
        .tx_data   (tx_data),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .reg_out   (reg_out),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] bytes;     // frame bytes, first byte in [47:40]
        int          len;
        logic [63:0] exp_regs;
        logic [7:0]  exp_tx;
        logic        exp_busy;  // busy just after the last byte is taken
        int          exp_err;
        int          exp_we;
        logic [23:0] exp_w0;    // {addr, data}
        logic [23:0] exp_w1;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write/err monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (fb_we) begin
            wlog.push_back({fb_addr, fb_wdata});
            chk("we_spacing", {63'd0, prev_we}, 64'd0);
        end
        if (err) err_cnt++;
        prev_we = fb_we;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic end_cs);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        if (end_cs) cs_n_sync = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic begin_frame();
        err_cnt = 0;
        wlog.delete();
        cs_n_sync = 1'b0;
        idle(2);
    endtask

    task automatic end_frame();
        cs_n_sync = 1'b1;
        idle(6);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx"},     {56'd0, tx_data}, 64'd0);
        chk({tag, "_we"},     {63'd0, fb_we},   64'd0);
        chk({tag, "_addr"},   {48'd0, fb_addr}, 64'd0);
        chk({tag, "_wdata"},  {56'd0, fb_wdata}, 64'd0);
        chk({tag, "_regs"},   reg_out,          64'd0);
        chk({tag, "_busy"},   {63'd0, busy},    64'd0);
        chk({tag, "_err"},    {63'd0, err},     64'd0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [7:0]  d;
        logic [23:0] w;

        vecs[0]  = '{48'h01035A000000, 3, 64'h00000000_5A000000, 8'h00, 1'b0, 0, 0, 24'h0, 24'h0};
        vecs[1]  = '{48'h0102C3000000, 3, 64'h00000000_5AC30000, 8'h00, 1'b0, 0, 0, 24'h0, 24'h0};
        vecs[2]  = '{48'h020200000000, 2, 64'h00000000_5AC30000, 8'hC3, 1'b0, 0, 0, 24'h0, 24'h0};
        vecs[3]  = '{48'h020900000000, 2, 64'h00000000_5AC30000, 8'hFF, 1'b0, 1, 0, 24'h0, 24'h0};
        vecs[4]  = '{48'h034B00112233, 6, 64'h00000000_5AC30000, 8'hFF, 1'b1, 1, 0, 24'h0, 24'h0};
        vecs[5]  = '{48'h034AFF112200, 5, 64'h00000000_5AC30000, 8'hFF, 1'b1, 0, 2, 24'h4AFF11, 24'h000022};
        vecs[6]  = '{48'h7E0105090000, 4, 64'h00000000_5AC30000, 8'hFF, 1'b1, 1, 0, 24'h0, 24'h0};
        vecs[7]  = '{48'h010509000000, 3, 64'h00000900_5AC30000, 8'hFF, 1'b0, 0, 0, 24'h0, 24'h0};
        vecs[8]  = '{48'h000107FF0000, 4, 64'hFF000900_5AC30000, 8'hFF, 1'b0, 0, 0, 24'h0, 24'h0};
        vecs[9]  = '{48'h0108AA000000, 3, 64'hFF000900_5AC30000, 8'hFF, 1'b0, 1, 0, 24'h0, 24'h0};
        vecs[10] = '{48'h020500000000, 2, 64'hFF000900_5AC30000, 8'h09, 1'b0, 0, 0, 24'h0, 24'h0};
        vecs[11] = '{48'h020700000000, 2, 64'hFF000900_5AC30000, 8'hFF, 1'b0, 0, 0, 24'h0, 24'h0};

        idle(3);
        rst = 1'b0;
        idle(1);
        check_reset_outputs("reset");

        for (int v = 0; v < 12; v++) begin
            begin_frame();
            for (int j = 0; j < vecs[v].len; j++) begin
                b = vecs[v].bytes[47-8*j -: 8];
                send_byte(b, 1'b0);
                if (j < vecs[v].len - 1) idle(3);
            end
            chk($sformatf("v%0d_regs", v), reg_out, vecs[v].exp_regs);
            chk($sformatf("v%0d_tx", v), {56'd0, tx_data}, {56'd0, vecs[v].exp_tx});
            chk($sformatf("v%0d_busy_mid", v), {63'd0, busy}, {63'd0, vecs[v].exp_busy});
            end_frame();
            chk($sformatf("v%0d_busy_end", v), {63'd0, busy}, 64'd0);
            chk($sformatf("v%0d_err_cnt", v), 64'(err_cnt), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_we_cnt", v), 64'(wlog.size()), 64'(vecs[v].exp_we));
            if (vecs[v].exp_we >= 1 && wlog.size() >= 1)
                chk($sformatf("v%0d_w0", v), {40'd0, wlog[0]}, {40'd0, vecs[v].exp_w0});
            if (vecs[v].exp_we >= 2 && wlog.size() >= 2)
                chk($sformatf("v%0d_w1", v), {40'd0, wlog[1]}, {40'd0, vecs[v].exp_w1});
        end

        // Long burst from 0x0010: AA then 300 more bytes.
        begin_frame();
        send_byte(8'h03, 1'b0); idle(3);
        send_byte(8'h00, 1'b0); idle(3);
        send_byte(8'h10, 1'b0); idle(3);
        for (int k = 0; k < 301; k++) begin
            d = (k == 0) ? 8'hAA : 8'(k * 7 + 3);
            send_byte(d, 1'b0);
            idle(2);
        end
        end_frame();
        chk("burst_cnt", 64'(wlog.size()), 64'd301);
        chk("burst_err", 64'(err_cnt), 64'd0);
        for (int k = 0; k < 301 && k < wlog.size(); k++) begin
            d = (k == 0) ? 8'hAA : 8'(k * 7 + 3);
            w = {16'h0010 + 16'(k), d};
            chk($sformatf("burst_w%0d", k), {40'd0, wlog[k]}, {40'd0, w});
        end

        // Last byte arrives together with the frame end: it must still be processed.
        begin_frame();
        send_byte(8'h01, 1'b0); idle(3);
        send_byte(8'h06, 1'b0); idle(3);
        send_byte(8'h44, 1'b1);
        chk("cs_same_cycle_regs", reg_out, 64'hFF440900_5AC30000);
        idle(6);
        chk("cs_same_cycle_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a pixel burst, frame kept open afterwards.
        begin_frame();
        send_byte(8'h03, 1'b0); idle(3);
        send_byte(8'h00, 1'b0); idle(3);
        send_byte(8'h20, 1'b0); idle(3);
        send_byte(8'h77, 1'b0);
        idle(4);
        chk("pre_rst_addr", {48'd0, fb_addr}, 64'h21);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        idle(2);
        send_byte(8'h01, 1'b0); idle(3);
        send_byte(8'h02, 1'b0); idle(3);
        send_byte(8'h3C, 1'b0);
        chk("post_rst_regs", reg_out, 64'h00000000_003C0000);
        idle(3);
        chk("post_rst_we_cnt", 64'(wlog.size()), 64'd1);
        chk("post_rst_err", 64'(err_cnt), 64'd0);
        end_frame();
        chk("post_rst_busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
